// File: rtl/lu_writeback_buffer.sv
// lu_writeback_buffer: aligns each issued LU op's destination register with the LU's
// registered result, then queues {rd, data, err} for the register-file write port.
module lu_writeback_buffer #(
    parameter int unsigned N      = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_op,
    input  logic [REG_AW-1:0]        issue_rd,
    output logic                     issue_ready,
    input  logic [N-1:0]             lu_c,
    output logic                     wb_valid,
    output logic [REG_AW-1:0]        wb_rd,
    output logic [N-1:0]             wb_data,
    output logic                     wb_err,
    input  logic                     wb_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;

    localparam logic [4:0] OP_LO = 5'b01010;
    localparam logic [4:0] OP_HI = 5'b10001;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [N-1:0]      data;
        logic              err;
    } wb_entry_t;

    // Stage P: the op whose result appears on lu_c in the following cycle
    logic              p_valid;
    logic [REG_AW-1:0] p_rd;
    logic              p_legal;

    // FIFO storage and bookkeeping
    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    wb_entry_t         head_q;

    // Next-state values
    logic              accept;
    logic              legal_op;
    logic              push;
    logic              pop;
    wb_entry_t         push_entry;
    logic [PW-1:0]     wr_ptr_next;
    logic [PW-1:0]     rd_ptr_next;
    logic [CW-1:0]     count_next;
    wb_entry_t         head_next;
    logic [OW-1:0]     occupancy;

    // Issue acceptance: the in-flight op reserves a slot so a push is never refused
    always_comb begin
        occupancy   = OW'(count) + OW'(p_valid);
        issue_ready = !rst && (occupancy < OW'(DEPTH));
        accept      = issue_valid && issue_ready;
        legal_op    = (issue_op >= OP_LO) && (issue_op <= OP_HI);
    end

    // Push/pop decisions, pointer and occupancy updates, and the next head entry
    always_comb begin
        push            = p_valid && (p_rd != '0);
        pop             = wb_valid && wb_ready;
        push_entry.rd   = p_rd;
        push_entry.data = p_legal ? lu_c : '0;
        push_entry.err  = ~p_legal;

        wr_ptr_next = push ? (wr_ptr + PW'(1)) : wr_ptr;
        rd_ptr_next = pop  ? (rd_ptr + PW'(1)) : rd_ptr;

        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase

        // The new head is the entry being written this cycle when it lands at the read slot
        head_next = '0;
        if (count_next != '0) begin
            if (push && (rd_ptr_next == wr_ptr)) begin
                head_next = push_entry;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    // Control state, pointers and registered head
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid  <= 1'b0;
            p_rd     <= '0;
            p_legal  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wb_valid <= 1'b0;
            head_q   <= '0;
        end else begin
            p_valid  <= accept;
            p_rd     <= issue_rd;
            p_legal  <= legal_op;
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            wb_valid <= (count_next != '0);
            head_q   <= head_next;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign wb_rd   = head_q.rd;
    assign wb_data = head_q.data;
    assign wb_err  = head_q.err;

endmodule

// File: tb/tb_lu_writeback_buffer.sv
// Scoreboard bench for lu_writeback_buffer: directed ops with hand-computed entries.
module tb_lu_writeback_buffer;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_op;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [31:0] lu_c;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic        wb_ready;
    logic [2:0]  count;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur_exp;
    logic        cur_has;
    logic [31:0] cur_lu;

    int n_chk;
    int n_fail;

    lu_writeback_buffer #(.N(32), .REG_AW(5), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .lu_c        (lu_c),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_err      (wb_err),
        .wb_ready    (wb_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LU model (1-cycle result) plus scoreboard push on every accepted op
    always @(posedge clk) begin
        if (issue_valid && issue_ready) begin
            lu_c <= cur_lu;
            if (cur_has) sb_q.push_back(cur_exp);
        end else begin
            lu_c <= 32'hDEAD_BEEF;
        end
        if (rst) sb_q.delete();
    end

    // Monitor: every write-back handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            exp_t e;
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_pop_unexpected: got rd=%0d data=0x%0h err=%0b, required no entry",
                         wb_rd, wb_data, wb_err);
            end else begin
                e = sb_q.pop_front();
                if ({wb_rd, wb_data, wb_err} !== e) begin
                    n_fail++;
                    $display("FAIL wb_pop: got rd=%0d data=0x%0h err=%0b, required rd=%0d data=0x%0h err=%0b",
                             wb_rd, wb_data, wb_err, e.rd, e.data, e.err);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] lu,
                         input logic has, input logic [31:0] edata, input logic eerr);
        issue_valid  = 1'b1;
        issue_op     = op;
        issue_rd     = rd;
        cur_lu       = lu;
        cur_has      = has;
        cur_exp.rd   = rd;
        cur_exp.data = edata;
        cur_exp.err  = eerr;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        cur_has     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_op = '0;
        issue_rd = '0;
        wb_ready = 1'b0;
        cur_lu = '0;
        cur_has = 1'b0;
        cur_exp = '0;

        // Reset held for two cycles
        next();
        next();
        rst = 1'b0;
        #1;
        chk("reset_wb_valid",    64'(wb_valid),    64'd0);
        chk("reset_count",       64'(count),       64'd0);
        chk("reset_issue_ready", 64'(issue_ready), 64'd1);
        chk("reset_head",        64'({wb_rd, wb_data, wb_err}), 64'd0);

        // Single op: accepted at T, visible at T+2, empty at T+3
        wb_ready = 1'b1;
        issue(5'b01010, 5'd3, 32'h0000_00F0, 1'b1, 32'h0000_00F0, 1'b0);
        next();
        idle();
        chk("single_t1_count", 64'(count),    64'd0);
        chk("single_t1_valid", 64'(wb_valid), 64'd0);
        next();
        chk("single_t2_valid", 64'(wb_valid), 64'd1);
        chk("single_t2_rd",    64'(wb_rd),    64'd3);
        chk("single_t2_data",  64'(wb_data),  64'h0000_00F0);
        chk("single_t2_err",   64'(wb_err),   64'd0);
        next();
        chk("single_t3_valid", 64'(wb_valid), 64'd0);
        chk("single_t3_count", 64'(count),    64'd0);

        // Back-pressure: only four ops fit, the fifth is held off
        wb_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            issue(5'b01011, 5'(i), 32'(32'h100 + i), 1'b1, 32'(32'h100 + i), 1'b0);
            chk("bp_issue_ready", 64'(issue_ready), (i <= 4) ? 64'd1 : 64'd0);
            next();
        end
        idle();
        chk("bp_full_count", 64'(count),       64'd4);
        chk("bp_full_ready", 64'(issue_ready), 64'd0);
        chk("bp_full_head",  64'(wb_rd),       64'd1);
        wb_ready = 1'b1;
        repeat (4) next();
        chk("bp_drain_count", 64'(count),    64'd0);
        chk("bp_drain_valid", 64'(wb_valid), 64'd0);

        // Simultaneous push and pop with two entries queued
        wb_ready = 1'b0;
        issue(5'b01100, 5'd10, 32'h0000_A0A0, 1'b1, 32'h0000_A0A0, 1'b0);
        next();
        issue(5'b01100, 5'd11, 32'h0000_B1B1, 1'b1, 32'h0000_B1B1, 1'b0);
        next();
        issue(5'b01100, 5'd12, 32'h0000_C2C2, 1'b1, 32'h0000_C2C2, 1'b0);
        next();
        idle();
        chk("simul_pre_count", 64'(count), 64'd2);
        chk("simul_pre_head",  64'(wb_rd), 64'd10);
        wb_ready = 1'b1;
        next();
        chk("simul_post_count", 64'(count), 64'd2);
        chk("simul_post_head",  64'(wb_rd), 64'd11);
        next();
        next();
        chk("simul_drain_count", 64'(count), 64'd0);

        // Illegal opcode stores zero data with err; rd==0 is dropped
        wb_ready = 1'b0;
        issue(5'b00011, 5'd7, 32'h0000_1234, 1'b1, 32'h0, 1'b1);
        next();
        issue(5'b10001, 5'd0, 32'h0000_0055, 1'b0, 32'h0, 1'b0);
        next();
        idle();
        chk("illegal_count", 64'(count),   64'd1);
        chk("illegal_rd",    64'(wb_rd),   64'd7);
        chk("illegal_data",  64'(wb_data), 64'd0);
        chk("illegal_err",   64'(wb_err),  64'd1);
        next();
        chk("r0_dropped_count", 64'(count), 64'd1);

        // Opcode range edges streamed with the port ready
        wb_ready = 1'b1;
        issue(5'b10010, 5'd9, 32'h0000_0077, 1'b1, 32'h0, 1'b1);
        next();
        issue(5'b10001, 5'd8, 32'h0000_0088, 1'b1, 32'h0000_0088, 1'b0);
        next();
        issue(5'b01001, 5'd6, 32'h0000_0066, 1'b1, 32'h0, 1'b1);
        next();
        idle();
        repeat (4) next();
        chk("edges_drain_count", 64'(count), 64'd0);

        // Reset with three queued entries and one op in flight
        wb_ready = 1'b0;
        for (int i = 20; i <= 23; i++) begin
            issue(5'b01111, 5'(i), 32'(32'h2000 + i), 1'b1, 32'(32'h2000 + i), 1'b0);
            next();
        end
        idle();
        chk("midrst_pre_count", 64'(count),       64'd3);
        chk("midrst_pre_ready", 64'(issue_ready), 64'd0);
        rst = 1'b1;
        next();
        chk("midrst_count",       64'(count),       64'd0);
        chk("midrst_valid",       64'(wb_valid),    64'd0);
        chk("midrst_ready_inrst", 64'(issue_ready), 64'd0);
        rst = 1'b0;
        next();
        chk("midrst_after_count", 64'(count),       64'd0);
        chk("midrst_after_valid", 64'(wb_valid),    64'd0);
        chk("midrst_after_ready", 64'(issue_ready), 64'd1);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
